// File: rtl/stub_event_pager_pkg.sv
// Purpose: shared types and constants for the stub event pager and its page memory.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package stub_event_pager_pkg;

    localparam int STUB_W      = 36;
    localparam int PAGE_AW_DEF = 6;
    localparam int BX_W        = 7;
    // The close record carries the count at the default page size; it must
    // hold the value PAGE_DEPTH itself, hence one extra bit.
    localparam int CNT_REC_W   = PAGE_AW_DEF + 1;

    // An all-zero word from the input stage means "no stub this clock".
    localparam logic [STUB_W-1:0] STUB_NULL = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Everything the downstream stage learns about a page when it closes.
    typedef struct packed {
        logic                 page;
        logic [CNT_REC_W-1:0] count;
        logic                 ovf;
        logic [BX_W-1:0]      bx;
    } page_close_t;

    // Event number advance with wrap at the end of the BX cycle.
    function automatic logic [BX_W-1:0] bx_next(input logic [BX_W-1:0] bx,
                                                input logic [BX_W-1:0] last);
        return (bx == last) ? '0 : bx + 1'b1;
    endfunction

endpackage

// File: rtl/stub_page_ram.sv
// Purpose: ping-pong page storage, simple dual port (one write, one read).
// Latency: read data registered, 1 clk after rd_addr; read-first on same-address collision.
// Backpressure: none; both ports accept every clock.
//
// Ports: clk/rst_n; wr_en/wr_addr/wr_data write port; rd_addr/rd_data read port.
// Only the read register is reset; the array keeps its contents.
module stub_page_ram #(
    parameter int AW = 7,
    parameter int DW = 36
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Combinational look-up of the pre-write array gives read-first
    // behaviour when a write hits the same address in the same clock.
    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/stub_event_pager.sv
// Purpose: frames the stub stream into EVT_LEN-clock events, fills ping-pong pages, announces closed pages.
// Latency: close announcement 1 clk after the closing clock; rd_data 1 clk after rd_addr.
// Backpressure: none; reader must finish a page within EVT_LEN clocks of its announcement.
//
// Ports: clk, reset (async active-low), BC0 framing marker, en run enable,
// stub_in (zero = no stub), rd_addr/rd_data random-access page read,
// page_done pulse with done_page/done_count/done_ovf/done_bx describing the page.
module stub_event_pager
    import stub_event_pager_pkg::*;
#(
    parameter int EVT_LEN = 8,
    parameter int PAGE_AW = PAGE_AW_DEF,
    parameter int MAX_BX  = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              BC0,
    input  logic              en,
    input  logic [STUB_W-1:0] stub_in,
    input  logic [PAGE_AW:0]  rd_addr,
    output logic [STUB_W-1:0] rd_data,
    output logic              page_done,
    output logic              done_page,
    output logic [PAGE_AW:0]  done_count,
    output logic              done_ovf,
    output logic [BX_W-1:0]   done_bx
);

    localparam int PAGE_DEPTH = 1 << PAGE_AW;
    localparam int CLK_W      = (EVT_LEN > 1) ? $clog2(EVT_LEN) : 1;

    localparam logic [CLK_W-1:0] EVT_LAST  = CLK_W'(EVT_LEN - 1);
    localparam logic [PAGE_AW:0] PAGE_FULL = (PAGE_AW + 1)'(PAGE_DEPTH);
    localparam logic [BX_W-1:0]  BX_LAST   = BX_W'(MAX_BX - 1);

    state_e           state_q,     state_d;
    logic [CLK_W-1:0] clk_cnt_q,   clk_cnt_d;
    logic [PAGE_AW:0] wr_cnt_q,    wr_cnt_d;
    logic             wr_page_q,   wr_page_d;
    logic             ovf_q,       ovf_d;
    logic [BX_W-1:0]  bx_q,        bx_d;
    logic             page_done_q, page_done_d;
    page_close_t      ann_q,       ann_d;

    logic             run_cycle;
    logic             resync;
    logic             stub_vld;
    logic             close;
    logic             wr_en;
    logic [PAGE_AW:0] cnt_now;
    logic             ovf_now;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        wr_page_d   = wr_page_q;
        ovf_d       = ovf_q;
        bx_d        = bx_q;
        page_done_d = 1'b0;
        ann_d       = ann_q;
        wr_en       = 1'b0;
        cnt_now     = wr_cnt_q;
        ovf_now     = ovf_q;
        close       = 1'b0;

        // The BC0 clock that leaves IDLE is already clock 0 of event 0,
        // so it is processed exactly like a RUN clock. A BC0 seen while
        // running instead ends the current event early.
        run_cycle = en && ((state_q == ST_RUN) || BC0);
        resync    = en && BC0 && (state_q == ST_RUN);
        stub_vld  = run_cycle && (stub_in != STUB_NULL);

        if (run_cycle) begin
            state_d = ST_RUN;

            if (stub_vld) begin
                if (wr_cnt_q == PAGE_FULL) begin
                    ovf_now = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    cnt_now = wr_cnt_q + 1'b1;
                end
            end

            close = resync || (clk_cnt_q == EVT_LAST);

            if (close) begin
                // The stub of the closing clock is already folded into
                // cnt_now / ovf_now, so the record describes the full page.
                page_done_d = 1'b1;
                ann_d.page  = wr_page_q;
                ann_d.count = CNT_REC_W'(cnt_now);
                ann_d.ovf   = ovf_now;
                ann_d.bx    = bx_q;
                wr_page_d   = ~wr_page_q;
                wr_cnt_d    = '0;
                ovf_d       = 1'b0;
                clk_cnt_d   = '0;
                bx_d        = resync ? '0 : bx_next(bx_q, BX_LAST);
            end else begin
                clk_cnt_d   = clk_cnt_q + 1'b1;
                wr_cnt_d    = cnt_now;
                ovf_d       = ovf_now;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            wr_page_q   <= 1'b0;
            ovf_q       <= 1'b0;
            bx_q        <= '0;
            page_done_q <= 1'b0;
            ann_q       <= '0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_page_q   <= wr_page_d;
            ovf_q       <= ovf_d;
            bx_q        <= bx_d;
            page_done_q <= page_done_d;
            ann_q       <= ann_d;
        end
    end

    stub_page_ram #(
        .AW (PAGE_AW + 1),
        .DW (STUB_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (wr_en),
        .wr_addr ({wr_page_q, wr_cnt_q[PAGE_AW-1:0]}),
        .wr_data (stub_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign page_done  = page_done_q;
    assign done_page  = ann_q.page;
    assign done_count = (PAGE_AW + 1)'(ann_q.count);
    assign done_ovf   = ann_q.ovf;
    assign done_bx    = ann_q.bx;

endmodule

// File: tb/tb_stub_event_pager.sv
// Purpose: randomized scoreboard bench for stub_event_pager (EVT_LEN 8 and 80 instances on shared inputs).
// Latency: expectations tagged with the clock edge at which the DUT must present them.
// Backpressure: n/a; the DUT has none, the bench drives every clock.
module tb_stub_event_pager;

    localparam int PAGE_DEPTH = 64;
    localparam int MAX_BX     = 100;

    typedef struct {
        int cyc;
        int page;
        int count;
        int ovf;
        int bx;
    } ann_t;

    typedef struct {
        int          cyc;
        logic [35:0] dat;
    } rd_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        bc0     = 1'b0;
    logic        en      = 1'b0;
    logic [35:0] stub_in = '0;
    logic [6:0]  rd_addr = '0;

    logic [35:0] rd_data0, rd_data1;
    logic        page_done0, page_done1;
    logic        done_page0, done_page1;
    logic [6:0]  done_count0, done_count1;
    logic        done_ovf0, done_ovf1;
    logic [6:0]  done_bx0, done_bx1;

    stub_event_pager #(.EVT_LEN(8), .PAGE_AW(6), .MAX_BX(100)) dut0 (
        .clk(clk), .reset(rst_n), .BC0(bc0), .en(en), .stub_in(stub_in),
        .rd_addr(rd_addr), .rd_data(rd_data0), .page_done(page_done0),
        .done_page(done_page0), .done_count(done_count0), .done_ovf(done_ovf0),
        .done_bx(done_bx0)
    );

    stub_event_pager #(.EVT_LEN(80), .PAGE_AW(6), .MAX_BX(100)) dut1 (
        .clk(clk), .reset(rst_n), .BC0(bc0), .en(en), .stub_in(stub_in),
        .rd_addr(rd_addr), .rd_data(rd_data1), .page_done(page_done1),
        .done_page(done_page1), .done_count(done_count1), .done_ovf(done_ovf1),
        .done_bx(done_bx1)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int pe_cnt = 0;
    int ovf_exp1  = 0;
    int ovf_seen1 = 0;

    always @(posedge clk) pe_cnt <= pe_cnt + 1;

    // Reference model: per instance, the open page as a stub count plus
    // drop flag, event position, and a flat image of both pages.
    int          evt_len [2];
    bit          m_run   [2];
    int          m_clk   [2];
    int          m_page  [2];
    int          m_bx    [2];
    int          m_n     [2];
    bit          m_drop  [2];
    logic [35:0] m_mem   [2][128];
    bit          m_memv  [2][128];

    ann_t ann_q0[$];
    ann_t ann_q1[$];
    rd_t  rd_q0[$];
    rd_t  rd_q1[$];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, pe_cnt, act, exp);
        end
    endfunction

    function automatic logic [35:0] rs();
        logic [35:0] v;
        v[31:0]  = $urandom();
        v[35:32] = 4'($urandom_range(0, 15));
        if (v == '0) v = 36'h1;
        return v;
    endfunction

    function automatic logic [6:0] ra();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 1'b0;
            m_clk[i]  = 0;
            m_page[i] = 0;
            m_bx[i]   = 0;
            m_n[i]    = 0;
            m_drop[i] = 1'b0;
        end
    endtask

    // Effect of the current inputs at the upcoming clock edge 'cyc'.
    task automatic model_step(input int i, input int cyc);
        ann_t a;
        rd_t  r;
        bit   early;
        if (m_memv[i][rd_addr]) begin
            r.cyc = cyc;
            r.dat = m_mem[i][rd_addr];
            if (i == 0) rd_q0.push_back(r); else rd_q1.push_back(r);
        end
        if (!en || (!m_run[i] && !bc0)) return;
        early    = m_run[i] && bc0;
        m_run[i] = 1'b1;
        if (stub_in != '0) begin
            if (m_n[i] < PAGE_DEPTH) begin
                m_mem[i][m_page[i] * PAGE_DEPTH + m_n[i]]  = stub_in;
                m_memv[i][m_page[i] * PAGE_DEPTH + m_n[i]] = 1'b1;
                m_n[i]++;
            end else begin
                m_drop[i] = 1'b1;
            end
        end
        if (early || m_clk[i] == evt_len[i] - 1) begin
            a.cyc   = cyc;
            a.page  = m_page[i];
            a.count = m_n[i];
            a.ovf   = int'(m_drop[i]);
            a.bx    = m_bx[i];
            if (i == 0) ann_q0.push_back(a);
            else begin
                ann_q1.push_back(a);
                if (m_drop[i]) ovf_exp1++;
            end
            m_page[i] = 1 - m_page[i];
            m_n[i]    = 0;
            m_drop[i] = 1'b0;
            m_clk[i]  = 0;
            m_bx[i]   = early ? 0 : (m_bx[i] + 1) % MAX_BX;
        end else begin
            m_clk[i]++;
        end
    endtask

    task automatic step(input logic b, input logic e, input logic [35:0] s, input logic [6:0] a);
        @(negedge clk);
        bc0     = b;
        en      = e;
        stub_in = s;
        rd_addr = a;
        if (rst_n) begin
            model_step(0, pe_cnt + 1);
            model_step(1, pe_cnt + 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bc0     = 1'b0;
        en      = 1'b0;
        stub_in = '0;
        model_reset();
        #1;
        check("rst_page_done0",  page_done0,  0);
        check("rst_done_page0",  done_page0,  0);
        check("rst_done_count0", done_count0, 0);
        check("rst_done_ovf0",   done_ovf0,   0);
        check("rst_done_bx0",    done_bx0,    0);
        check("rst_rd_data0",    rd_data0,    0);
        check("rst_page_done1",  page_done1,  0);
        check("rst_done_count1", done_count1, 0);
        check("rst_done_bx1",    done_bx1,    0);
        check("rst_rd_data1",    rd_data1,    0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        rd_addr = ra();
        model_step(0, pe_cnt + 1);
        model_step(1, pe_cnt + 1);
    endtask

    task automatic mon(input int i, input logic pd, input logic dp, input logic [6:0] dc,
                       input logic dov, input logic [6:0] dbx, input logic [35:0] rdd);
        ann_t a;
        rd_t  r;
        bit   have_a = 1'b0;
        bit   have_r = 1'b0;
        if (i == 0) begin
            if (rd_q0.size() > 0 && rd_q0[0].cyc == pe_cnt) begin r = rd_q0.pop_front(); have_r = 1'b1; end
            if (ann_q0.size() > 0 && ann_q0[0].cyc == pe_cnt) begin a = ann_q0.pop_front(); have_a = 1'b1; end
        end else begin
            if (rd_q1.size() > 0 && rd_q1[0].cyc == pe_cnt) begin r = rd_q1.pop_front(); have_r = 1'b1; end
            if (ann_q1.size() > 0 && ann_q1[0].cyc == pe_cnt) begin a = ann_q1.pop_front(); have_a = 1'b1; end
        end
        if (have_r) check($sformatf("rd_data%0d", i), rdd, r.dat);
        if (have_a) begin
            check($sformatf("page_done%0d", i),  pd,  1);
            check($sformatf("done_page%0d", i),  dp,  a.page);
            check($sformatf("done_count%0d", i), dc,  a.count);
            check($sformatf("done_ovf%0d", i),   dov, a.ovf);
            check($sformatf("done_bx%0d", i),    dbx, a.bx);
            if (i == 1 && dov) ovf_seen1++;
        end else begin
            check($sformatf("idle_page_done%0d", i), pd, 0);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            mon(0, page_done0, done_page0, done_count0, done_ovf0, done_bx0, rd_data0);
            mon(1, page_done1, done_page1, done_count1, done_ovf1, done_bx1, rd_data1);
        end
    end

    initial begin
        evt_len[0] = 8;
        evt_len[1] = 80;
        model_reset();
        do_reset();

        // First event: stubs on clocks 0, 2, 7, then read them back.
        step(1'b1, 1'b1, 36'h1, ra());
        step(1'b0, 1'b1, 36'h0, ra());
        step(1'b0, 1'b1, 36'h2, ra());
        repeat (4) step(1'b0, 1'b1, 36'h0, ra());
        step(1'b0, 1'b1, 36'h3, ra());
        step(1'b0, 1'b1, 36'h0, 7'd0);
        step(1'b0, 1'b1, 36'h0, 7'd1);
        step(1'b0, 1'b1, 36'h0, 7'd2);

        // Empty events across the event-number wrap.
        repeat (8 * 101) step(1'b0, 1'b1, 36'h0, ra());

        // Resync, then BC0 on clock 3 of event 5 after two stubs.
        step(1'b1, 1'b1, 36'h0, ra());
        repeat (40) step(1'b0, 1'b1, 36'h0, ra());
        step(1'b0, 1'b1, 36'h55, ra());
        step(1'b0, 1'b1, 36'h66, ra());
        step(1'b0, 1'b1, 36'h0, ra());
        step(1'b1, 1'b1, 36'h0, ra());
        repeat (16) step(1'b0, 1'b1, 36'h0, ra());

        // en low for 4 clocks mid-event with live stubs.
        repeat (3) step(1'b0, 1'b1, rs(), ra());
        repeat (4) step(1'b0, 1'b0, rs(), ra());
        repeat (21) step(1'b0, 1'b1, rs(), ra());

        // Overflow on the 80-clock instance, then a sparse follow-up page.
        step(1'b1, 1'b1, 36'h0, ra());
        repeat (70) step(1'b0, 1'b1, rs(), ra());
        repeat (10) step(1'b0, 1'b1, 36'h0, ra());
        repeat (80) step(1'b0, 1'b1, ($urandom_range(0, 3) == 0) ? rs() : 36'h0, ra());

        // Random traffic with occasional BC0 and en gaps.
        repeat (2000) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 1) == 1) ? rs() : 36'h0, ra());
        end

        // Reset with three stubs in an open page: no announcement, stay idle until BC0.
        step(1'b1, 1'b1, 36'h0, ra());
        repeat (3) step(1'b0, 1'b1, rs(), ra());
        do_reset();
        repeat (20) step(1'b0, 1'b1, rs(), ra());
        step(1'b1, 1'b1, rs(), ra());
        repeat (20) step(1'b0, 1'b1, rs(), ra());
        repeat (4) step(1'b0, 1'b0, 36'h0, ra());
        @(negedge clk);

        check("ann_q0_left", ann_q0.size(), 0);
        check("ann_q1_left", ann_q1.size(), 0);
        check("rd_q0_left",  rd_q0.size(),  0);
        check("rd_q1_left",  rd_q1.size(),  0);
        check("ovf_pages1",  ovf_seen1,     ovf_exp1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
